// File: rtl/fp_cvt_pkg.sv
// Shared constants for the double -> 64-bit integer converter: rounding-mode
// encodings, fflags bit positions, FSM state codes and integer range limits.
package fp_cvt_pkg;

  // Rounding modes as they arrive on in_rm; codes 101..111 fall back to RNE.
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag vector.
  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

  // Converter FSM state codes.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ALIGN = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Integer range limits used for saturation.
  localparam logic [63:0] INT64_MAX  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] INT64_MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] UINT64_MAX = 64'hFFFF_FFFF_FFFF_FFFF;

  // Double-precision exponent constants.
  localparam logic [10:0] BIAS        = 11'd1023;
  localparam logic [10:0] EXP_SPECIAL = 11'h7FF;
  // Biased exponent at which the unbiased exponent reaches 64.
  localparam logic [10:0] EXP_BIG     = 11'd1087;

  // Right-shift distance that brings the binary point of {hidden,f,11'b0}
  // just below acc[0]: 63-e for e in [0,63], capped at 65 for tiny values
  // (65 pushes every bit through the guard into sticky), 0 when e >= 64.
  function automatic logic [6:0] calc_shift(input logic [10:0] exp_bits);
    logic [10:0] diff;
    logic [6:0]  r;
    diff = 11'd0;
    if (exp_bits >= EXP_BIG) begin
      r = 7'd0;
    end else begin
      diff = (BIAS + 11'd63) - exp_bits;
      if (diff > 11'd65) begin
        r = 7'd65;
      end else begin
        r = diff[6:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fcvt_round_sat.sv
// Combinational rounding and saturation stage: turns the aligned integer
// part plus guard/sticky into the final 64-bit result and fflags.
module fcvt_round_sat
  import fp_cvt_pkg::*;
(
  input  logic [63:0] acc,
  input  logic        g,
  input  logic        st,
  input  logic        s,
  input  logic [2:0]  rm,
  input  logic        is_unsigned,
  input  logic        is_nan,
  input  logic        is_inf,
  input  logic        is_big,
  output logic [63:0] result,
  output logic [4:0]  fflags
);

  localparam logic [64:0] POS_LIMIT = {1'b0, INT64_MAX};
  localparam logic [64:0] NEG_LIMIT = {1'b0, INT64_MIN};

  logic        inc;
  logic [64:0] mag;
  logic        nv;
  logic        nx;

  // Round-up decision from LSB, guard, sticky and sign.
  always_comb begin
    inc = 1'b0;
    case (rm)
      RM_RNE:  inc = g & (st | acc[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s & (g | st);
      RM_RUP:  inc = ~s & (g | st);
      RM_RMM:  inc = g;
      default: inc = g & (st | acc[0]);
    endcase
  end

  assign mag = {1'b0, acc} + {64'd0, inc};

  // Pick the result by priority: NaN, infinity/huge, then finite range checks.
  always_comb begin
    result = 64'd0;
    nv     = 1'b0;
    if (is_nan) begin
      nv     = 1'b1;
      result = is_unsigned ? UINT64_MAX : INT64_MAX;
    end else if (is_inf || is_big) begin
      nv = 1'b1;
      if (is_unsigned) begin
        result = s ? 64'd0 : UINT64_MAX;
      end else begin
        result = s ? INT64_MIN : INT64_MAX;
      end
    end else if (!is_unsigned) begin
      if ((!s && (mag > POS_LIMIT)) || (s && (mag > NEG_LIMIT))) begin
        nv     = 1'b1;
        result = s ? INT64_MIN : INT64_MAX;
      end else begin
        result = s ? (64'd0 - mag[63:0]) : mag[63:0];
      end
    end else begin
      if (!s && mag[64]) begin
        nv     = 1'b1;
        result = UINT64_MAX;
      end else if (s && (mag != 65'd0)) begin
        nv     = 1'b1;
        result = 64'd0;
      end else if (s) begin
        result = 64'd0;
      end else begin
        result = mag[63:0];
      end
    end
  end

  assign nx = (g | st) & ~nv;

  // Assemble the flag vector; divide-by-zero, overflow and underflow never fire here.
  always_comb begin
    fflags        = 5'd0;
    fflags[FF_NV] = nv;
    fflags[FF_DZ] = 1'b0;
    fflags[FF_OF] = 1'b0;
    fflags[FF_UF] = 1'b0;
    fflags[FF_NX] = nx;
  end

endmodule

// File: rtl/fcvt_fp2int.sv
// Iterative IEEE-754 double to 64-bit integer converter (FCVT.L.D/FCVT.LU.D).
// A single right shifter aligns the mantissa SHIFT_STEP bits per cycle, then
// one rounding cycle produces the registered result.
module fcvt_fp2int
  import fp_cvt_pkg::*;
#(
  parameter int SHIFT_STEP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [2:0]  in_rm,
  input  logic        in_unsigned,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [4:0]  out_fflags
);

  localparam logic [6:0] STEP = 7'(SHIFT_STEP);

  logic [1:0]  state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic        g_q, g_d;
  logic        st_q, st_d;
  logic [6:0]  r_q, r_d;
  logic        s_q, s_d;
  logic [2:0]  rm_q, rm_d;
  logic        uns_q, uns_d;
  logic        nan_q, nan_d;
  logic        inf_q, inf_d;
  logic        big_q, big_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_data_q, out_data_d;
  logic [4:0]  out_fflags_q, out_fflags_d;
  logic        in_ready_q, in_ready_d;

  logic [10:0]  exp_bits;
  logic [51:0]  frac_bits;
  logic         is_special;
  logic [6:0]   k;
  logic [129:0] shift_wide;
  logic [63:0]  rs_result;
  logic [4:0]   rs_fflags;

  assign exp_bits   = in_data[62:52];
  assign frac_bits  = in_data[51:0];
  assign is_special = (exp_bits == EXP_SPECIAL);

  // Shared shifter: {acc,g} moves right by k, low half collects the bits that fall off.
  assign k          = (r_q < STEP) ? r_q : STEP;
  assign shift_wide = {acc_q, g_q, 65'd0} >> k;

  fcvt_round_sat u_round_sat (
    .acc         (acc_q),
    .g           (g_q),
    .st          (st_q),
    .s           (s_q),
    .rm          (rm_q),
    .is_unsigned (uns_q),
    .is_nan      (nan_q),
    .is_inf      (inf_q),
    .is_big      (big_q),
    .result      (rs_result),
    .fflags      (rs_fflags)
  );

  // Next-state and datapath update for capture, alignment, rounding and hand-off.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    g_d          = g_q;
    st_d         = st_q;
    r_d          = r_q;
    s_d          = s_q;
    rm_d         = rm_q;
    uns_d        = uns_q;
    nan_d        = nan_q;
    inf_d        = inf_q;
    big_d        = big_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_fflags_d = out_fflags_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          acc_d   = {(exp_bits != 11'd0), frac_bits, 11'd0};
          g_d     = 1'b0;
          st_d    = 1'b0;
          s_d     = in_data[63];
          rm_d    = in_rm;
          uns_d   = in_unsigned;
          nan_d   = is_special && (frac_bits != 52'd0);
          inf_d   = is_special && (frac_bits == 52'd0);
          big_d   = !is_special && (exp_bits >= EXP_BIG);
          r_d     = is_special ? 7'd0 : calc_shift(exp_bits);
          state_d = ST_ALIGN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ALIGN: begin
        if (r_q == 7'd0) begin
          state_d = ST_ROUND;
        end else begin
          acc_d = shift_wide[129:66];
          g_d   = shift_wide[65];
          st_d  = st_q | (|shift_wide[64:0]);
          r_d   = r_q - k;
        end
      end
      ST_ROUND: begin
        out_data_d   = rs_result;
        out_fflags_d = rs_fflags;
        out_valid_d  = 1'b1;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers; reset discards any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= 64'd0;
      g_q          <= 1'b0;
      st_q         <= 1'b0;
      r_q          <= 7'd0;
      s_q          <= 1'b0;
      rm_q         <= 3'd0;
      uns_q        <= 1'b0;
      nan_q        <= 1'b0;
      inf_q        <= 1'b0;
      big_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 64'd0;
      out_fflags_q <= 5'd0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      g_q          <= g_d;
      st_q         <= st_d;
      r_q          <= r_d;
      s_q          <= s_d;
      rm_q         <= rm_d;
      uns_q        <= uns_d;
      nan_q        <= nan_d;
      inf_q        <= inf_d;
      big_q        <= big_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_fflags_q <= out_fflags_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_fflags = out_fflags_q;

endmodule

// File: tb/tb_fcvt_fp2int.sv
// Self-checking bench for fcvt_fp2int: directed cases with fixed expectations,
// randomized cases against a fixed-point reference model, a scoreboard queue
// popped on each output handshake, plus back-pressure and reset checks.
module tb_fcvt_fp2int;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = 64'd0;
  logic [2:0]  in_rm = 3'd0;
  logic        in_unsigned = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [4:0]  out_fflags;

  int n_chk = 0;
  int n_err = 0;
  int sent_cnt = 0;
  int done_cnt = 0;

  logic [63:0] exp_data_q[$];
  logic [4:0]  exp_fl_q[$];

  always #5 clk = ~clk;

  fcvt_fp2int #(.SHIFT_STEP(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_rm       (in_rm),
    .in_unsigned (in_unsigned),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_fflags  (out_fflags)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sat_val(input logic s, input logic uns);
    logic [63:0] v;
    if (uns) v = s ? 64'd0 : 64'hFFFF_FFFF_FFFF_FFFF;
    else     v = s ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    return v;
  endfunction

  // Reference: exact fixed-point value with 128 fraction bits, then rounding.
  function automatic void ref_cvt(input logic [63:0] d, input logic [2:0] rm, input logic uns,
                                  output logic [63:0] res, output logic [4:0] fl);
    logic          s;
    logic [10:0]   ex;
    logic [52:0]   mant;
    int            e;
    int            sh;
    logic [191:0]  fx;
    logic [63:0]   ip;
    logic [127:0]  frac;
    logic          half, below, inexact, inc, nv;
    logic [64:0]   m;
    s = d[63];
    ex = d[62:52];
    mant = {(ex != 11'd0), d[51:0]};
    e = int'(ex) - 1023;
    nv = 1'b0;
    inexact = 1'b0;
    res = 64'd0;
    if (ex == 11'h7FF) begin
      nv = 1'b1;
      if (d[51:0] != 52'd0) res = uns ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h7FFF_FFFF_FFFF_FFFF;
      else res = sat_val(s, uns);
    end else if (e >= 64) begin
      nv = 1'b1;
      res = sat_val(s, uns);
    end else begin
      sh = 128 + e - 52;
      if (sh >= 0) fx = {139'd0, mant} << sh;
      else fx = (mant != 53'd0) ? 192'd1 : 192'd0;
      ip = fx[191:128];
      frac = fx[127:0];
      half = frac[127];
      below = |frac[126:0];
      inexact = |frac;
      case (rm)
        3'b001:  inc = 1'b0;
        3'b010:  inc = s & inexact;
        3'b011:  inc = ~s & inexact;
        3'b100:  inc = half;
        default: inc = half & (below | ip[0]);
      endcase
      m = {1'b0, ip} + {64'd0, inc};
      if (!uns) begin
        if (!s && (m > 65'h0_7FFF_FFFF_FFFF_FFFF)) begin
          nv = 1'b1; res = 64'h7FFF_FFFF_FFFF_FFFF;
        end else if (s && (m > 65'h0_8000_0000_0000_0000)) begin
          nv = 1'b1; res = 64'h8000_0000_0000_0000;
        end else begin
          res = s ? (64'd0 - m[63:0]) : m[63:0];
        end
      end else begin
        if (s) begin
          res = 64'd0; nv = (m != 65'd0);
        end else if (m[64]) begin
          res = 64'hFFFF_FFFF_FFFF_FFFF; nv = 1'b1;
        end else begin
          res = m[63:0];
        end
      end
    end
    fl = {nv, 3'b000, inexact & ~nv};
  endfunction

  // Scoreboard monitor: compare every accepted result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_data_q.size() == 0) begin
        check_val("sb_underflow", 64'(exp_data_q.size()), 64'd1);
      end else begin
        check_val("data", out_data, exp_data_q.pop_front());
        check_val("flags", 64'(out_fflags), 64'(exp_fl_q.pop_front()));
      end
      done_cnt++;
    end
  end

  // Drive one operand, push its expectation, optionally measure latency to out_valid.
  task automatic issue(input logic [63:0] d, input logic [2:0] rm, input logic uns,
                       input logic [63:0] ed, input logic [4:0] ef,
                       input logic wait_valid, output int lat);
    logic accepted;
    logic seen;
    accepted = 1'b0;
    seen = 1'b0;
    lat = 0;
    @(negedge clk);
    in_data = d; in_rm = rm; in_unsigned = uns; in_valid = 1'b1;
    exp_data_q.push_back(ed);
    exp_fl_q.push_back(ef);
    sent_cnt++;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin accepted = 1'b1; break; end
      @(negedge clk);
    end
    check_val("accept", 64'(accepted), 64'd1);
    if (accepted) begin
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1;
      if (wait_valid) begin
        for (int i = 0; i < 300; i++) begin
          @(negedge clk);
          if (out_valid) begin seen = 1'b1; break; end
          lat++;
        end
        check_val("out_valid_seen", 64'(seen), 64'd1);
      end
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      if (done_cnt == sent_cnt) break;
      @(negedge clk);
    end
    check_val("complete", 64'(done_cnt), 64'(sent_cnt));
  endtask

  task automatic run_one(input string tag, input logic [63:0] d, input logic [2:0] rm,
                         input logic uns, input logic [63:0] ed, input logic [4:0] ef);
    int lat;
    issue(d, rm, uns, ed, ef, 1'b1, lat);
    wait_done();
  endtask

  initial begin
    int lat;
    logic [63:0] rd, ed;
    logic [4:0] ef;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_data", out_data, 64'd0);
    check_val("rst_out_fflags", 64'(out_fflags), 64'd0);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1.5 RNE signed with latency measurement
    issue(64'h3FF8000000000000, 3'b000, 1'b0, 64'd2, 5'h01, 1'b1, lat);
    check_val("lat_1p5", 64'(lat), 64'd11);
    wait_done();

    // -2.5 in every rounding mode
    run_one("m2p5_rne", 64'hC004000000000000, 3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 5'h01);
    run_one("m2p5_rtz", 64'hC004000000000000, 3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 5'h01);
    run_one("m2p5_rdn", 64'hC004000000000000, 3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 5'h01);
    run_one("m2p5_rmm", 64'hC004000000000000, 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 5'h01);
    run_one("m2p5_rup", 64'hC004000000000000, 3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 5'h01);

    // Range edges
    run_one("p2e63_s", 64'h43E0000000000000, 3'b000, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 5'h10);
    run_one("m2e63_s", 64'hC3E0000000000000, 3'b000, 1'b0, 64'h8000_0000_0000_0000, 5'h00);
    run_one("p2e63_u", 64'h43E0000000000000, 3'b000, 1'b1, 64'h8000_0000_0000_0000, 5'h00);

    // Specials
    issue(64'h7FF8000000000000, 3'b000, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 5'h10, 1'b1, lat);
    check_val("lat_nan", 64'(lat), 64'd3);
    wait_done();
    run_one("minf_u",  64'hFFF0000000000000, 3'b000, 1'b1, 64'd0, 5'h10);
    run_one("m0p25_u", 64'hBFD0000000000000, 3'b001, 1'b1, 64'd0, 5'h01);
    run_one("m0p75_u", 64'hBFE8000000000000, 3'b000, 1'b1, 64'd0, 5'h10);
    run_one("mzero",   64'h8000000000000000, 3'b000, 1'b0, 64'd0, 5'h00);
    run_one("subn_rup", 64'h0000000000000001, 3'b011, 1'b0, 64'd1, 5'h01);

    // Back-pressure: hold the result for 5 cycles
    out_ready = 1'b0;
    issue(64'h4059000000000000, 3'b000, 1'b0, 64'd100, 5'h00, 1'b1, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("hold_valid", 64'(out_valid), 64'd1);
      check_val("hold_data", out_data, 64'd100);
      check_val("hold_fflags", 64'(out_fflags), 64'd0);
      check_val("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    wait_done();

    // Reset in the middle of alignment
    issue(64'h3FF8000000000000, 3'b000, 1'b0, 64'd2, 5'h01, 1'b0, lat);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", 64'(out_valid), 64'd0);
    check_val("midrst_in_ready", 64'(in_ready), 64'd1);
    exp_data_q.delete();
    exp_fl_q.delete();
    sent_cnt = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("postrst_in_ready", 64'(in_ready), 64'd1);
    run_one("postrst_3", 64'h4008000000000000, 3'b000, 1'b0, 64'd3, 5'h00);

    // Randomized operands against the reference model
    for (int i = 0; i < 80; i++) begin
      rd = {$urandom, $urandom};
      if (i % 10 == 0) rd[62:52] = 11'd0;
      else if (i % 10 == 1) rd[62:52] = 11'h7FF;
      else rd[62:52] = 11'($urandom_range(990, 1095));
      ref_cvt(rd, 3'($urandom_range(0, 7)), 1'b0, ed, ef);
      in_rm = 3'($urandom_range(0, 7));
      in_unsigned = 1'($urandom_range(0, 1));
      ref_cvt(rd, in_rm, in_unsigned, ed, ef);
      run_one("rand", rd, in_rm, in_unsigned, ed, ef);
    end

    check_val("sb_empty", 64'(exp_data_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
